// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the femtoRV32
// datapath/memory. master = control unit, slave = datapath side.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] ALUOp;
  logic       ALUSrc;
  logic       RegWrite;
  logic       MemtoReg;
  logic       illegal_op;
  logic [2:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, MemRead, MemWrite, IRWrite, PCWrite, Branch,
           ALUOp, ALUSrc, RegWrite, MemtoReg, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, MemRead, MemWrite, IRWrite, PCWrite, Branch,
           ALUOp, ALUSrc, RegWrite, MemtoReg, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle femtoRV32 datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared memory port and
// produces every datapath enable plus the ALUOp code.
module multicycle_control_unit (
  input  logic                              clk,
  input  logic                              rst,
  multicycle_control_unit_if.master         bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  // Instruction class; 0 doubles as "illegal" so reset clears to a harmless value.
  typedef enum logic [2:0] {
    C_ILL = 3'd0,
    C_R   = 3'd1,
    C_I   = 3'd2,
    C_LD  = 3'd3,
    C_ST  = 3'd4,
    C_BR  = 3'd5,
    C_SYS = 3'd6
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_dec;

  logic       mem_req, mem_rd, mem_wr, ir_wr, pc_wr, branch;
  logic [1:0] alu_op;
  logic       alu_src, reg_wr, mem2reg, illegal;

  // Opcode -> class, only consumed while in DECODE.
  always_comb begin
    cls_dec = C_ILL;
    case (bus.opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LD;
      7'b0100011: cls_dec = C_ST;
      7'b1100011: cls_dec = C_BR;
      7'b1110011: cls_dec = C_SYS;
      default:    cls_dec = C_ILL;
    endcase
  end

  // State and latched class; class captured on the DECODE exit edge so later
  // opcode changes cannot disturb EXECUTE/MEM/WRITEBACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
    end
  end

  // Next state and Moore outputs (IRWrite/PCWrite additionally gated by mem_ready).
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    branch  = 1'b0;
    alu_op  = 2'b00;
    alu_src = 1'b0;
    reg_wr  = 1'b0;
    mem2reg = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        mem_rd  = 1'b1;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls_dec)
          C_SYS:   state_d = S_HALT;
          C_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (cls_q)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_I: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LD, C_ST: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BR: begin
            alu_op  = 2'b01;
            branch  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        mem_req = 1'b1;
        mem_rd  = (cls_q == C_LD);
        mem_wr  = (cls_q == C_ST);
        if (bus.mem_ready) state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_wr  = 1'b1;
        mem2reg = (cls_q == C_LD);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low combinationally, including mid-access strobes.
  assign bus.mem_req    = ~rst & mem_req;
  assign bus.MemRead    = ~rst & mem_rd;
  assign bus.MemWrite   = ~rst & mem_wr;
  assign bus.IRWrite    = ~rst & ir_wr;
  assign bus.PCWrite    = ~rst & pc_wr;
  assign bus.Branch     = ~rst & branch;
  assign bus.ALUOp      = rst ? 2'b00 : alu_op;
  assign bus.ALUSrc     = ~rst & alu_src;
  assign bus.RegWrite   = ~rst & reg_wr;
  assign bus.MemtoReg   = ~rst & mem2reg;
  assign bus.illegal_op = ~rst & illegal;
  assign bus.state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected output words are
// pushed to a scoreboard queue as stimulus is applied and popped at the
// following negedge for comparison.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if cu_if();

  multicycle_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (cu_if)
  );

  // {state, req, rd, wr, ir, pc, br, aluop, src, rw, m2r, ill}
  logic [14:0] obs;
  assign obs = {cu_if.state, cu_if.mem_req, cu_if.MemRead, cu_if.MemWrite,
                cu_if.IRWrite, cu_if.PCWrite, cu_if.Branch, cu_if.ALUOp,
                cu_if.ALUSrc, cu_if.RegWrite, cu_if.MemtoReg, cu_if.illegal_op};

  int total = 0;
  int bad   = 0;
  logic [14:0] sb_q[$];

  typedef struct {
    string       name;
    logic [6:0]  op;
    int          n;
    logic [14:0] exp [5];
  } vec_t;

  vec_t vecs[7];

  function automatic logic [14:0] ow(input int st, input bit req, input bit rd,
      input bit wr, input bit ir, input bit pc, input bit br, input logic [1:0] aop,
      input bit src, input bit rw, input bit m2r, input bit ill);
    logic [2:0] s3;
    s3 = st[2:0];
    return {s3, req, rd, wr, ir, pc, br, aop, src, rw, m2r, ill};
  endfunction

  // One clock: drive inputs, push expectation, compare at negedge, advance.
  task automatic cyc(input string nm, input bit r, input bit rdy,
                     input logic [6:0] op, input logic [14:0] e);
    logic [14:0] want;
    rst = r;
    cu_if.mem_ready = rdy;
    cu_if.opcode = op;
    sb_q.push_back(e);
    @(negedge clk);
    want = sb_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, obs, want, $time);
    end
    @(posedge clk);
    #1;
  endtask

  logic [14:0] Z, F_HOLD, F_GO, DEC;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] junk;
    Z      = ow(0,0,0,0,0,0,0,2'b00,0,0,0,0);
    F_HOLD = ow(0,1,1,0,0,0,0,2'b00,0,0,0,0);
    F_GO   = ow(0,1,1,0,1,1,0,2'b00,0,0,0,0);
    DEC    = ow(1,0,0,0,0,0,0,2'b00,0,0,0,0);

    vecs[0] = '{"rtype", 7'b0110011, 4,
      '{F_GO, DEC, ow(2,0,0,0,0,0,0,2'b10,0,0,0,0), ow(4,0,0,0,0,0,0,2'b00,0,1,0,0), Z}};
    vecs[1] = '{"ialu", 7'b0010011, 4,
      '{F_GO, DEC, ow(2,0,0,0,0,0,0,2'b10,1,0,0,0), ow(4,0,0,0,0,0,0,2'b00,0,1,0,0), Z}};
    vecs[2] = '{"load", 7'b0000011, 5,
      '{F_GO, DEC, ow(2,0,0,0,0,0,0,2'b00,1,0,0,0), ow(3,1,1,0,0,0,0,2'b00,1,0,0,0),
        ow(4,0,0,0,0,0,0,2'b00,0,1,1,0)}};
    vecs[3] = '{"store", 7'b0100011, 4,
      '{F_GO, DEC, ow(2,0,0,0,0,0,0,2'b00,1,0,0,0), ow(3,1,0,1,0,0,0,2'b00,1,0,0,0), Z}};
    vecs[4] = '{"branch", 7'b1100011, 3,
      '{F_GO, DEC, ow(2,0,0,0,0,0,1,2'b01,0,0,0,0), Z, Z}};
    vecs[5] = '{"illegal_lui", 7'b0110111, 2,
      '{F_GO, ow(1,0,0,0,0,0,0,2'b00,0,0,0,1), Z, Z, Z}};
    vecs[6] = '{"illegal_ff", 7'b1111111, 2,
      '{F_GO, ow(1,0,0,0,0,0,0,2'b00,0,0,0,1), Z, Z, Z}};

    cu_if.opcode = 7'b0;
    cu_if.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held two cycles, then FETCH waits for memory.
    cyc("reset0", 1, 0, 7'h00, Z);
    cyc("reset1", 1, 1, 7'h00, Z);
    cyc("fetch_after_reset", 0, 0, 7'h00, F_HOLD);

    // Table: each instruction with mem_ready tied high; opcode scrambled after DECODE.
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        junk = (c >= 2) ? 7'($urandom) : vecs[v].op;
        cyc(vecs[v].name, 0, 1, junk, vecs[v].exp[c]);
      end
    end
    cyc("back_to_fetch", 0, 0, 7'h00, F_HOLD);

    // LOAD with one fetch wait and three MEM wait cycles.
    cyc("ld_fetch_go", 0, 1, 7'b0000011, F_GO);
    cyc("ld_dec", 0, 1, 7'b0000011, DEC);
    cyc("ld_exe", 0, 1, 7'b0000011, ow(2,0,0,0,0,0,0,2'b00,1,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("ld_mem_wait", 0, 0, 7'b0110011, ow(3,1,1,0,0,0,0,2'b00,1,0,0,0));
    cyc("ld_mem_done", 0, 1, 7'b0110011, ow(3,1,1,0,0,0,0,2'b00,1,0,0,0));
    cyc("ld_wb", 0, 0, 7'b0110011, ow(4,0,0,0,0,0,0,2'b00,0,1,1,0));

    // STORE interrupted by reset during a MEM wait: strobe must drop at once.
    cyc("st_fetch", 0, 1, 7'b0100011, F_GO);
    cyc("st_dec", 0, 0, 7'b0100011, DEC);
    cyc("st_exe", 0, 0, 7'b0100011, ow(2,0,0,0,0,0,0,2'b00,1,0,0,0));
    cyc("st_mem_wait", 0, 0, 7'b0100011, ow(3,1,0,1,0,0,0,2'b00,1,0,0,0));
    cyc("st_rst_in_mem", 1, 0, 7'b0100011, Z);
    cyc("st_after_rst", 0, 0, 7'b0100011, F_HOLD);

    // SYSTEM halts; outputs stay low while mem_ready toggles; reset recovers.
    cyc("sys_fetch", 0, 1, 7'b1110011, F_GO);
    cyc("sys_dec", 0, 1, 7'b1110011, DEC);
    for (int i = 0; i < 20; i++)
      cyc("halt", 0, i[0], 7'b0110011, ow(5,0,0,0,0,0,0,2'b00,0,0,0,0));
    cyc("halt_rst_ready", 1, 1, 7'b0110011, Z);
    cyc("halt_recover", 0, 1, 7'b0110011, F_GO);
    cyc("post_halt_dec", 0, 1, 7'b0110011, DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
